// File: rtl/wait_cmd_initiator.sv
// wait_cmd_initiator
// Simulation-side command initiator for the wait-event responder. It takes one
// WTR/WTF command at a time from the scenario sequencer, presents it to the
// responder and holds the selection until the responder reports completion.
// Bad opcodes are rejected without touching the responder. A watchdog bounds
// the WAIT phase. Per-command status and saturating pass/error counts are
// reported.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   i_cmd_valid    command present from the sequencer
//   o_cmd_ready    idle, a command can be accepted
//   i_cmd_args     command strings: [0] opcode, [1] alias, [2] timeout, [3] unit
//   o_sel_wait     responder select
//   o_args_valid   one-cycle argument strobe to the responder
//   o_args         arguments latched at accept
//   i_wait_done    responder completion (only looked at in WAIT)
//   o_cmd_done     one-cycle completion pulse to the sequencer
//   o_cmd_status   0 OK, 1 REJECT, 2 WATCHDOG (valid with o_cmd_done)
//   o_ok_count     commands finished OK (saturating)
//   o_err_count    commands finished REJECT/WATCHDOG (saturating)
module wait_cmd_initiator #(
  parameter int          ARGS_NB      = 5,
  parameter int unsigned GUARD_CYCLES = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  string       i_cmd_args [ARGS_NB],
  output logic        o_sel_wait,
  output logic        o_args_valid,
  output string       o_args [ARGS_NB],
  input  logic        i_wait_done,
  output logic        o_cmd_done,
  output logic [1:0]  o_cmd_status,
  output logic [15:0] o_ok_count,
  output logic [15:0] o_err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_REJECT = 2'd1;
  localparam logic [1:0] ST_WDOG   = 2'd2;

  state_t      r_state;
  logic        r_sel_wait;
  logic        r_args_valid;
  logic        r_cmd_done;
  logic [1:0]  r_cmd_status;
  logic [15:0] r_ok_count;
  logic [15:0] r_err_count;
  logic [31:0] r_wd_cnt;

  state_t      w_next_state;
  logic        w_next_sel;
  logic        w_next_args_valid;
  logic        w_next_done;
  logic [1:0]  w_next_status;
  logic        w_accept;
  logic        w_opcode_ok;
  logic        w_wd_expire;
  logic        w_wd_fire;
  logic        w_wd_clr;
  logic        w_wd_inc;
  logic        w_inc_ok;
  logic        w_inc_err;

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_sel_wait   = r_sel_wait;
  assign o_args_valid = r_args_valid;
  assign o_cmd_done   = r_cmd_done;
  assign o_cmd_status = r_cmd_status;
  assign o_ok_count   = r_ok_count;
  assign o_err_count  = r_err_count;

  // Next-state and next-output decode; every output target defaults to the
  // inactive value so that sel_wait drops automatically on entry to DONE.
  always_comb begin
    w_next_state      = r_state;
    w_next_sel        = 1'b0;
    w_next_args_valid = 1'b0;
    w_next_done       = 1'b0;
    w_next_status     = r_cmd_status;
    w_accept          = 1'b0;
    w_wd_fire         = 1'b0;
    w_wd_clr          = 1'b0;
    w_wd_inc          = 1'b0;
    w_inc_ok          = 1'b0;
    w_inc_err         = 1'b0;
    w_opcode_ok       = (i_cmd_args[0] == "WTR") || (i_cmd_args[0] == "WTF");
    // Watchdog compares against limit-1 so DONE lands GUARD_CYCLES WAIT edges in.
    w_wd_expire       = (GUARD_CYCLES != 32'd0) &&
                        (r_wd_cnt == (GUARD_CYCLES - 32'd1));
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          if (w_opcode_ok) begin
            w_next_state      = S_ISSUE;
            w_next_sel        = 1'b1;
            w_next_args_valid = 1'b1;
          end else begin
            w_next_state  = S_DONE;
            w_next_done   = 1'b1;
            w_next_status = ST_REJECT;
            w_inc_err     = 1'b1;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
        w_next_sel   = 1'b1;
        w_wd_clr     = 1'b1;
      end
      S_WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (i_wait_done) begin
          w_next_state  = S_DONE;
          w_next_done   = 1'b1;
          w_next_status = ST_OK;
          w_inc_ok      = 1'b1;
        end else if (w_wd_expire) begin
          w_next_state  = S_DONE;
          w_next_done   = 1'b1;
          w_next_status = ST_WDOG;
          w_inc_err     = 1'b1;
          w_wd_fire     = 1'b1;
        end else begin
          w_next_state = S_WAIT;
          w_next_sel   = 1'b1;
          w_wd_inc     = 1'b1;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, registered outputs, argument latch, watchdog and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sel_wait   <= 1'b0;
      r_args_valid <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_cmd_status <= ST_OK;
      r_ok_count   <= 16'd0;
      r_err_count  <= 16'd0;
      r_wd_cnt     <= 32'd0;
      for (int i = 0; i < ARGS_NB; i++) begin
        o_args[i] <= "";
      end
    end else begin
      r_state      <= w_next_state;
      r_sel_wait   <= w_next_sel;
      r_args_valid <= w_next_args_valid;
      r_cmd_done   <= w_next_done;
      r_cmd_status <= w_next_status;
      if (w_accept) begin
        for (int i = 0; i < ARGS_NB; i++) begin
          o_args[i] <= i_cmd_args[i];
        end
      end
      if (w_wd_clr) begin
        r_wd_cnt <= 32'd0;
      end else if (w_wd_inc) begin
        r_wd_cnt <= r_wd_cnt + 32'd1;
      end
      if (w_inc_ok && (r_ok_count != 16'hFFFF)) begin
        r_ok_count <= r_ok_count + 16'd1;
      end
      if (w_inc_err && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
      if (w_accept && !w_opcode_ok) begin
        $display("Error: %0t wait_cmd_initiator rejected opcode '%s'", $time, i_cmd_args[0]);
      end
      if (w_wd_fire) begin
        $display("Error: %0t wait_cmd_initiator watchdog expired after %0d WAIT cycles",
                 $time, GUARD_CYCLES);
      end
    end
  end

endmodule

// File: tb/tb_wait_cmd_initiator.sv
module tb_wait_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  string       cmd_args [5];
  logic        sel_wait;
  logic        args_valid;
  string       args_out [5];
  logic        wait_done;
  logic        cmd_done;
  logic [1:0]  cmd_status;
  logic [15:0] ok_count;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wait_cmd_initiator #(.ARGS_NB(5), .GUARD_CYCLES(32'd20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_args   (cmd_args),
    .o_sel_wait   (sel_wait),
    .o_args_valid (args_valid),
    .o_args       (args_out),
    .i_wait_done  (wait_done),
    .o_cmd_done   (cmd_done),
    .o_cmd_status (cmd_status),
    .o_ok_count   (ok_count),
    .o_err_count  (err_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
    end
  endtask

  // done_at: edge offset from the accept edge at which wait_done is sampled (0 = never)
  // lat:     offset k such that cmd_done is high after edge E+k
  typedef struct {
    string      op;
    string      sig;
    int         done_at;
    logic [1:0] status;
    int         lat;
    int         ok;
    int         err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int hits;
    vecs[0] = '{"WTR", "SIG0", 12, 2'd0, 12, 1, 0};
    vecs[1] = '{"XYZ", "SIG1",  0, 2'd1,  0, 1, 1};
    vecs[2] = '{"WTF", "SIG2",  0, 2'd2, 21, 1, 2};
    vecs[3] = '{"WTR", "SIG3", 21, 2'd0, 21, 2, 2};
    vecs[4] = '{"WTF", "SIG4",  2, 2'd0,  2, 3, 2};
    vecs[5] = '{"wtr", "SIG5",  0, 2'd1,  0, 3, 3};
    vecs[6] = '{"WTR", "SIG6", 20, 2'd0, 20, 4, 3};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    wait_done = 1'b0;
    for (int i = 0; i < 5; i++) cmd_args[i] = "";
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", cmd_ready, 1);
    chk("reset sel_wait", sel_wait, 0);
    chk("reset args_valid", args_valid, 0);
    chk("reset cmd_done", cmd_done, 0);
    chk("reset status", cmd_status, 0);
    chk("reset ok_count", ok_count, 0);
    chk("reset err_count", err_count, 0);
    chk_s("reset args0", args_out[0], "");
    rst_n = 1'b1;

    // wait_done while idle must be ignored
    wait_done = 1'b1;
    hits = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (cmd_done || !cmd_ready || sel_wait) hits++;
    end
    wait_done = 1'b0;
    chk("idle wait_done ignored", hits, 0);
    chk("idle ok_count", ok_count, 0);

    // table-driven single commands
    for (int i = 0; i < 7; i++) begin
      int done_k;
      int sel_n;
      int av_n;
      logic sel_at_done;
      cmd_args[0] = vecs[i].op;
      cmd_args[1] = vecs[i].sig;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      done_k = -1;
      sel_n = 0;
      av_n = 0;
      sel_at_done = 1'b1;
      for (int k = 0; k < 40; k++) begin
        wait_done = (vecs[i].done_at != 0) && (k + 1 == vecs[i].done_at);
        @(negedge clk);
        if (k == 0) begin
          chk_s($sformatf("vec%0d args0", i), args_out[0], vecs[i].op);
          chk_s($sformatf("vec%0d args1", i), args_out[1], vecs[i].sig);
        end
        if (cmd_done) begin
          done_k = k;
          sel_at_done = sel_wait;
          break;
        end
        sel_n += int'(sel_wait);
        av_n += int'(args_valid);
        @(posedge clk);
        #1;
      end
      wait_done = 1'b0;
      chk($sformatf("vec%0d latency", i), done_k, vecs[i].lat);
      chk($sformatf("vec%0d status", i), cmd_status, vecs[i].status);
      chk($sformatf("vec%0d sel_at_done", i), sel_at_done, 0);
      chk($sformatf("vec%0d sel_cycles", i), sel_n, vecs[i].lat);
      chk($sformatf("vec%0d args_valid_pulses", i), av_n, (vecs[i].status == 2'd1) ? 0 : 1);
      if (done_k >= 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      chk($sformatf("vec%0d done_low", i), cmd_done, 0);
      chk($sformatf("vec%0d ready", i), cmd_ready, 1);
      chk($sformatf("vec%0d ok_count", i), ok_count, vecs[i].ok);
      chk($sformatf("vec%0d err_count", i), err_count, vecs[i].err);
    end

    // back-to-back: WTF then WTR with valid held; accepts at E1 and E1+5
    cmd_args[0] = "WTF";
    cmd_args[1] = "BB_A";
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_args[0] = "WTR";
    cmd_args[1] = "BB_B";
    for (int k = 0; k < 11; k++) begin
      wait_done = (k + 1 == 3) || (k + 1 == 8);
      @(negedge clk);
      chk($sformatf("b2b sel k%0d", k), sel_wait,
          ((k <= 2) || (k >= 5 && k <= 7)) ? 1 : 0);
      chk($sformatf("b2b done k%0d", k), cmd_done, ((k == 3) || (k == 8)) ? 1 : 0);
      chk_s($sformatf("b2b args0 k%0d", k), args_out[0], (k < 5) ? "WTF" : "WTR");
      chk_s($sformatf("b2b args1 k%0d", k), args_out[1], (k < 5) ? "BB_A" : "BB_B");
      if (k == 5) cmd_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    wait_done = 1'b0;
    @(negedge clk);
    chk("b2b ok_count", ok_count, 6);
    chk("b2b err_count", err_count, 3);

    // reset during WAIT
    cmd_args[0] = "WTR";
    cmd_args[1] = "RST";
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre-reset sel_wait", sel_wait, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset sel_wait", sel_wait, 0);
    chk("midreset ready", cmd_ready, 1);
    chk("midreset cmd_done", cmd_done, 0);
    chk("midreset args_valid", args_valid, 0);
    chk("midreset ok_count", ok_count, 0);
    chk("midreset err_count", err_count, 0);
    chk_s("midreset args0", args_out[0], "");
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (cmd_done || sel_wait) hits++;
    end
    chk("post-reset no done", hits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
